hazard_ctrl: RTL and testbench

- Pipeline hazard controller for the 5-stage MIPS pipeline. It works alongside the EX-stage forwarding unit and covers every hazard that forwarding cannot resolve.
- Stalls:
  - load-use stalls,
  - branch-in-ID operand stalls,
  - multi-cycle data-memory waits, which freeze the whole pipe.
- Flushes IF/ID on a taken branch.
- Keeps saturating stall/flush performance counters and a sticky memory-timeout flag.

---
 rtl/hazard_ctrl_pkg.sv | 25 ++
 rtl/hazard_ctrl_detect.sv | 38 +++
 rtl/hazard_ctrl.sv | 140 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller.
// Holds the FSM state encoding, the hard-wired zero register number,
// the default counter width / memory timeout, and the register-match
// helper used by the hazard detector.
package hazard_ctrl_pkg;

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_MEM_WAIT = 1'b1
  } state_t;

  localparam logic [4:0] REG_ZERO        = 5'd0;
  localparam int         CNT_W_DEF       = 16;
  localparam int         MEM_TIMEOUT_DEF = 64;

  // A producer register matches the ID instruction only if it is not $zero,
  // because writes to $zero never create a real dependency.
  function automatic logic reg_hit(input logic [4:0] r,
                                   input logic [4:0] rs,
                                   input logic [4:0] rt,
                                   input logic       uses_rt);
    return (r != REG_ZERO) && ((r == rs) || (uses_rt && (r == rt)));
  endfunction

endpackage

// File: rtl/hazard_ctrl_detect.sv
// hazard_detect: purely combinational hazard detection for the ID stage.
// Ports:
//   ifid_rs / ifid_rt / ifid_uses_rt  - source operands of the ID instruction
//   id_is_branch                      - ID instruction compares in ID
//   idex_memread / idex_regwrite / idex_dest - producer in EX
//   exmem_memread / exmem_dest        - producer in MEM
//   load_use / br_ex / br_mem         - hazards forwarding cannot cover
module hazard_detect
  import hazard_ctrl_pkg::*;
(
  input  logic [4:0] ifid_rs,
  input  logic [4:0] ifid_rt,
  input  logic       ifid_uses_rt,
  input  logic       id_is_branch,
  input  logic       idex_memread,
  input  logic       idex_regwrite,
  input  logic [4:0] idex_dest,
  input  logic       exmem_memread,
  input  logic [4:0] exmem_dest,
  output logic       load_use,
  output logic       br_ex,
  output logic       br_mem
);

  logic hit_ex;
  logic hit_mem;

  assign hit_ex  = reg_hit(idex_dest,  ifid_rs, ifid_rt, ifid_uses_rt);
  assign hit_mem = reg_hit(exmem_dest, ifid_rs, ifid_rt, ifid_uses_rt);

  // Loaded data only exists after MEM, so EX-stage forwarding is too late.
  assign load_use = idex_memread && hit_ex;
  // The branch compare sits in ID, ahead of the EX forwarding path, so any
  // in-flight ALU result or a load still in MEM must be waited for.
  assign br_ex    = id_is_branch && idex_regwrite && hit_ex;
  assign br_mem   = id_is_branch && exmem_memread && hit_mem;

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush controller for the 5-stage MIPS pipeline.
// Ports:
//   clk, reset (sync, active high)
//   ifid_*, id_*, idex_*, exmem_*    - pipeline register fields for detection
//   mem_req / mem_ready              - data-memory handshake from MEM
//   pc_write, ifid_write             - front-end enables
//   ifid_flush, idex_bubble          - NOP injection into IF/ID and ID/EX
//   pipe_hold                        - freeze ID/EX, EX/MEM, MEM/WB
//   stall_cnt, flush_cnt             - saturating performance counters
//   mem_timeout                      - sticky memory wait overrun flag
// Control outputs are combinational so they act on the coming edge.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       ifid_rs,
  input  logic [4:0]       ifid_rt,
  input  logic             ifid_uses_rt,
  input  logic             id_is_branch,
  input  logic             id_branch_taken,
  input  logic             idex_memread,
  input  logic             idex_regwrite,
  input  logic [4:0]       idex_dest,
  input  logic             exmem_memread,
  input  logic [4:0]       exmem_dest,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             pipe_hold,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             mem_timeout
);

  localparam int WAIT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              load_use;
  logic              br_ex;
  logic              br_mem;
  logic              stall;
  logic              mem_miss;

  hazard_detect u_detect (
    .ifid_rs       (ifid_rs),
    .ifid_rt       (ifid_rt),
    .ifid_uses_rt  (ifid_uses_rt),
    .id_is_branch  (id_is_branch),
    .idex_memread  (idex_memread),
    .idex_regwrite (idex_regwrite),
    .idex_dest     (idex_dest),
    .exmem_memread (exmem_memread),
    .exmem_dest    (exmem_dest),
    .load_use      (load_use),
    .br_ex         (br_ex),
    .br_mem        (br_mem)
  );

  assign stall    = load_use || br_ex || br_mem;
  assign mem_miss = mem_req && !mem_ready;

  // NOTE: every output gets a default at the top of the block so no path
  // leaves one unassigned, which would otherwise infer a latch.
  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    pipe_hold   = 1'b0;
    if (reset) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (state == ST_MEM_WAIT || mem_miss) begin
      // Memory wait freezes everything; hazards are re-evaluated once the
      // frozen registers move again.
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      pipe_hold  = 1'b1;
    end else if (stall) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end else begin
      // Only reached with stall low, so a flush never uses stale operands.
      ifid_flush = id_is_branch && id_branch_taken;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_RUN;
      wait_cnt    <= '0;
      stall_cnt   <= '0;
      flush_cnt   <= '0;
      mem_timeout <= 1'b0;
    end else begin
      if (!pc_write && stall_cnt != CNT_MAX)
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (ifid_flush && flush_cnt != CNT_MAX)
        flush_cnt <= flush_cnt + CNT_W'(1);

      case (state)
        ST_RUN: begin
          if (mem_miss) begin
            state    <= ST_MEM_WAIT;
            wait_cnt <= '0;
          end
        end
        ST_MEM_WAIT: begin
          // After a timeout the pipe stays frozen until reset.
          if (mem_ready && !mem_timeout) begin
            state    <= ST_RUN;
            wait_cnt <= '0;
          end else if (wait_cnt == WAIT_LAST) begin
            if (!mem_ready)
              mem_timeout <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        default: state <= ST_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl. Two instances share the
// stimulus: a main one (CNT_W=16, MEM_TIMEOUT=4) and a narrow one (CNT_W=2)
// used for counter saturation.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  ifid_rs, ifid_rt, idex_dest, exmem_dest;
  logic        ifid_uses_rt, id_is_branch, id_branch_taken;
  logic        idex_memread, idex_regwrite, exmem_memread;
  logic        mem_req, mem_ready;

  logic        pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold;
  logic [15:0] stall_cnt, flush_cnt;
  logic        mem_timeout;

  logic        n_pc_write, n_ifid_write, n_ifid_flush, n_idex_bubble, n_pipe_hold;
  logic [1:0]  n_stall_cnt, n_flush_cnt;
  logic        n_mem_timeout;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.CNT_W(16), .MEM_TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_uses_rt(ifid_uses_rt),
    .id_is_branch(id_is_branch), .id_branch_taken(id_branch_taken),
    .idex_memread(idex_memread), .idex_regwrite(idex_regwrite),
    .idex_dest(idex_dest), .exmem_memread(exmem_memread),
    .exmem_dest(exmem_dest), .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .idex_bubble(idex_bubble), .pipe_hold(pipe_hold),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .mem_timeout(mem_timeout)
  );

  hazard_ctrl #(.CNT_W(2), .MEM_TIMEOUT(64)) dut_narrow (
    .clk(clk), .reset(reset),
    .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_uses_rt(ifid_uses_rt),
    .id_is_branch(id_is_branch), .id_branch_taken(id_branch_taken),
    .idex_memread(idex_memread), .idex_regwrite(idex_regwrite),
    .idex_dest(idex_dest), .exmem_memread(exmem_memread),
    .exmem_dest(exmem_dest), .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_write(n_pc_write), .ifid_write(n_ifid_write), .ifid_flush(n_ifid_flush),
    .idex_bubble(n_idex_bubble), .pipe_hold(n_pipe_hold),
    .stall_cnt(n_stall_cnt), .flush_cnt(n_flush_cnt), .mem_timeout(n_mem_timeout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1-2 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Control outputs packed as {pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold}.
  task automatic chk_ctrl(input string tag, input logic [4:0] exp);
    chk(tag, 32'({pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold}), 32'(exp));
  endtask

  task automatic clear_inputs();
    ifid_rs = 5'd0; ifid_rt = 5'd0; ifid_uses_rt = 1'b0;
    id_is_branch = 1'b0; id_branch_taken = 1'b0;
    idex_memread = 1'b0; idex_regwrite = 1'b0; idex_dest = 5'd0;
    exmem_memread = 1'b0; exmem_dest = 5'd0;
    mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // ---------- reset state ----------
    clear_inputs();
    reset = 1'b1;
    settle();
    chk_ctrl("reset_ctrl", 5'b00110);
    tick();
    tick();
    reset = 1'b0;
    settle();
    chk("reset_stall_cnt", 32'(stall_cnt), 32'd0);
    chk("reset_flush_cnt", 32'(flush_cnt), 32'd0);
    chk("reset_timeout",   32'(mem_timeout), 32'd0);
    chk_ctrl("idle_ctrl", 5'b11000);

    // ---------- load-use on rs ----------
    idex_memread = 1'b1; idex_dest = 5'd8; ifid_rs = 5'd8;
    settle();
    chk_ctrl("lu_ctrl", 5'b00010);
    tick();
    chk("lu_stall_cnt", 32'(stall_cnt), 32'd1);
    idex_memread = 1'b0;
    settle();
    chk_ctrl("lu_after", 5'b11000);
    tick();
    chk("lu_stall_cnt_hold", 32'(stall_cnt), 32'd1);

    // rt match ignored when the instruction does not read rt
    idex_memread = 1'b1; idex_dest = 5'd8; ifid_rs = 5'd3; ifid_rt = 5'd8;
    ifid_uses_rt = 1'b0;
    settle();
    chk_ctrl("lu_rt_unused", 5'b11000);
    ifid_uses_rt = 1'b1;
    settle();
    chk_ctrl("lu_rt_used", 5'b00010);

    // ---------- zero register ----------
    do_reset();
    idex_memread = 1'b1; idex_dest = 5'd0; ifid_rs = 5'd0;
    settle();
    chk_ctrl("zero_ctrl", 5'b11000);
    tick();
    chk("zero_stall_cnt", 32'(stall_cnt), 32'd0);

    // ---------- ALU result feeding a branch vs. a plain R-type ----------
    do_reset();
    idex_regwrite = 1'b1; idex_dest = 5'd5; ifid_rs = 5'd5;
    settle();
    chk_ctrl("alu_no_branch", 5'b11000);
    id_is_branch = 1'b1; id_branch_taken = 1'b1;
    settle();
    chk_ctrl("br_ex_stall", 5'b00010);

    // ---------- load then dependent beq ----------
    do_reset();
    idex_memread = 1'b1; idex_regwrite = 1'b1; idex_dest = 5'd9;
    id_is_branch = 1'b1; ifid_rt = 5'd9; ifid_uses_rt = 1'b1; ifid_rs = 5'd2;
    id_branch_taken = 1'b1;
    settle();
    chk_ctrl("ldbr_c1", 5'b00010);
    tick();
    idex_memread = 1'b0; idex_regwrite = 1'b0; idex_dest = 5'd0;
    exmem_memread = 1'b1; exmem_dest = 5'd9;
    settle();
    chk_ctrl("ldbr_c2", 5'b00010);
    tick();
    exmem_memread = 1'b0;
    settle();
    chk_ctrl("ldbr_c3_flush", 5'b11100);
    tick();
    chk("ldbr_stall_cnt", 32'(stall_cnt), 32'd2);
    chk("ldbr_flush_cnt", 32'(flush_cnt), 32'd1);
    id_is_branch = 1'b0;
    settle();
    chk_ctrl("ldbr_after", 5'b11000);

    // ---------- memory wait ----------
    do_reset();
    mem_req = 1'b1; mem_ready = 1'b0;
    settle();
    chk_ctrl("mw_c1", 5'b00001);
    tick();
    id_is_branch = 1'b1; id_branch_taken = 1'b1;  // must be ignored while waiting
    settle();
    chk_ctrl("mw_c2", 5'b00001);
    tick();
    settle();
    chk_ctrl("mw_c3", 5'b00001);
    tick();
    id_is_branch = 1'b0; id_branch_taken = 1'b0;
    mem_ready = 1'b1;
    settle();
    chk_ctrl("mw_c4", 5'b00001);
    tick();
    mem_req = 1'b0; mem_ready = 1'b0;
    settle();
    chk_ctrl("mw_back_run", 5'b11000);
    chk("mw_stall_cnt", 32'(stall_cnt), 32'd4);
    chk("mw_flush_cnt", 32'(flush_cnt), 32'd0);
    chk("mw_timeout", 32'(mem_timeout), 32'd0);

    // single-cycle access: no hold, no state change
    mem_req = 1'b1; mem_ready = 1'b1;
    settle();
    chk_ctrl("mw_single", 5'b11000);
    tick();
    mem_req = 1'b0; mem_ready = 1'b0;
    settle();
    chk_ctrl("mw_single_after", 5'b11000);

    // ---------- timeout (MEM_TIMEOUT=4) ----------
    do_reset();
    mem_req = 1'b1; mem_ready = 1'b0;
    tick();                     // entry cycle in RUN
    tick(); tick(); tick();     // three MEM_WAIT cycles
    chk("to_before", 32'(mem_timeout), 32'd0);
    tick();                     // fourth MEM_WAIT cycle
    chk("to_set", 32'(mem_timeout), 32'd1);
    chk("to_stall_cnt", 32'(stall_cnt), 32'd5);
    tick(); tick();
    chk("to_sticky", 32'(mem_timeout), 32'd1);
    settle();
    chk_ctrl("to_frozen", 5'b00001);
    mem_req = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    settle();
    chk("to_reset_flag", 32'(mem_timeout), 32'd0);
    chk("to_reset_cnt", 32'(stall_cnt), 32'd0);
    chk_ctrl("to_reset_run", 5'b11000);

    // ---------- saturation (narrow instance, CNT_W=2) ----------
    do_reset();
    idex_memread = 1'b1; idex_dest = 5'd12; ifid_rs = 5'd12;
    for (int i = 1; i <= 6; i++) begin
      tick();
      chk($sformatf("sat_narrow_%0d", i), 32'(n_stall_cnt), (i < 3) ? 32'(i) : 32'd3);
    end
    chk("sat_wide", 32'(stall_cnt), 32'd6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
